// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor, one BLOCK-bit slice per stage with valid/ready flow control.
// Define CLA_PIPE_OVF_EN to add the signed-overflow output ovf.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int STAGES = WIDTH / BLOCK;
  localparam int GROUPS = BLOCK / 4;
  logic [WIDTH-1:0] a_q[STAGES], a_d[STAGES], b_q[STAGES], b_d[STAGES], s_q[STAGES], s_d[STAGES];
  logic [WIDTH-1:0] x_a[STAGES], x_b[STAGES], x_s[STAGES];
  logic             v_q[STAGES], v_d[STAGES], c_q[STAGES], c_d[STAGES], x_c[STAGES], x_v[STAGES];
  logic [BLOCK:0]   r[STAGES];
  logic             advance;
  // 4-bit CLA groups chained through group generate/propagate; returns {carry_out, sum}
  function automatic logic [BLOCK:0] cla_slice(input logic [BLOCK-1:0] x, y, input logic ci);
    logic [BLOCK-1:0] g, p;
    logic [BLOCK:0] c;
    logic [GROUPS:0] gc;
    logic [3:0] g4, p4;
    g = x & y;
    p = x ^ y;
    gc[0] = ci;
    for (int j = 0; j < GROUPS; j++) begin
      g4 = g[4*j +: 4];
      p4 = p[4*j +: 4];
      gc[j+1] = g4[3] | (p4[3] & g4[2]) | (&p4[3:2] & g4[1]) | (&p4[3:1] & g4[0]) | (&p4 & gc[j]);
    end
    c[0] = gc[0];
    for (int i = 0; i < BLOCK; i++)
      c[i+1] = ((i + 1) % 4 == 0) ? gc[(i+1)/4] : (g[i] | (p[i] & c[i]));
    return {c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction
  assign advance   = !(v_q[STAGES-1] && !out_ready);
  assign in_ready  = advance;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  always_comb begin
    x_a[0] = a;
    x_b[0] = sub ? ~b : b;
    x_c[0] = sub | cin;
    x_v[0] = in_valid;
    x_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      x_a[k] = a_q[k-1];
      x_b[k] = b_q[k-1];
      x_c[k] = c_q[k-1];
      x_v[k] = v_q[k-1];
      x_s[k] = s_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      r[k]   = cla_slice(x_a[k][k*BLOCK +: BLOCK], x_b[k][k*BLOCK +: BLOCK], x_c[k]);
      a_d[k] = advance ? x_a[k] : a_q[k];
      b_d[k] = advance ? x_b[k] : b_q[k];
      s_d[k] = advance ? (x_s[k] | (WIDTH'(r[k][BLOCK-1:0]) << (k * BLOCK))) : s_q[k];
      c_d[k] = advance ? r[k][BLOCK] : c_q[k];
      v_d[k] = advance ? x_v[k] : v_q[k];
    end
  end
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else begin
      v_q <= v_d;
      s_q <= s_d;
      c_q <= c_d;
    end
  end
`ifdef CLA_PIPE_OVF_EN
  logic ovf_q, ovf_d;
  // carry into the MSB recovered from the final slice's sum bit and operand bits
  always_comb
    ovf_d = advance ? (r[STAGES-1][BLOCK-1] ^ x_a[STAGES-1][WIDTH-1] ^ x_b[STAGES-1][WIDTH-1] ^ r[STAGES-1][BLOCK])
                    : ovf_q;
  always_ff @(posedge clk)
    ovf_q <= rst ? 1'b0 : ovf_d;
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: vector table, hand-written stall/reset sequences and random traffic checked against an arithmetic scoreboard.
module tb_cla_pipe_adder;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [31:0] a, b, sum;
`ifdef CLA_PIPE_OVF_EN
  logic        ovf;
`endif
  int pass_cnt = 0, total = 0, out_cnt = 0;
  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;
  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] es;
    logic        ec;
  } vec_t;
  res_t q[$];
  vec_t tv[9];

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(32), .BLOCK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef CLA_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );

  function automatic res_t model(input logic [31:0] x, y, input logic ci, sb);
    res_t r;
    logic [32:0] t;
    logic [31:0] yy;
    yy = sb ? ~y : y;
    t = {1'b0, x} + {1'b0, yy} + {32'd0, sb ? 1'b1 : ci};
    r.s = t[31:0];
    r.c = t[32];
    r.o = (x[31] == yy[31]) && (t[31] != x[31]);
    return r;
  endfunction

  task automatic chk(input string n, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, y, input logic ci, sb);
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    res_t r;
    if (rst) q.delete();
    else begin
      if (out_valid && out_ready) begin
        out_cnt++;
        if (q.size() == 0) begin
          total++;
          $display("FAIL sb_extra: got sum %h with no expected result pending", sum);
        end else begin
          r = q.pop_front();
          chk("model_sum", {1'b0, sum}, {1'b0, r.s});
          chk("model_cout", {32'd0, cout}, {32'd0, r.c});
`ifdef CLA_PIPE_OVF_EN
          chk("model_ovf", {32'd0, ovf}, {32'd0, r.o});
`endif
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, c0;
    logic [31:0] held;
    logic [31:0] exp2[4];
    tv[0] = '{32'd100, 32'd200, 1'b0, 1'b0, 32'd300, 1'b0};
    tv[1] = '{32'h0000_00FF, 32'd1, 1'b0, 1'b0, 32'h0000_0100, 1'b0};
    tv[2] = '{32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1};
    tv[3] = '{32'd50, 32'd40, 1'b0, 1'b1, 32'd10, 1'b1};
    tv[4] = '{32'd40, 32'd50, 1'b0, 1'b1, 32'hFFFF_FFF6, 1'b0};
    tv[5] = '{32'd50, 32'd40, 1'b1, 1'b1, 32'd10, 1'b1};
    tv[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1};
    tv[7] = '{32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0};
    tv[8] = '{32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1};
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {32'd0, out_valid}, 33'd0);
    chk("rst_sum", {1'b0, sum}, 33'd0);
    chk("rst_cout", {32'd0, cout}, 33'd0);
    chk("rst_in_ready", {32'd0, in_ready}, 33'd1);
    for (int i = 0; i < 9; i++) begin
      send(tv[i].a, tv[i].b, tv[i].cin, tv[i].sub);
      lat = 1;
      while (!out_valid && lat < 20) begin
        step();
        lat++;
      end
      chk("vec_latency", 33'(lat), 33'd4);
      chk("vec_sum", {1'b0, sum}, {1'b0, tv[i].es});
      chk("vec_cout", {32'd0, cout}, {32'd0, tv[i].ec});
      step();
      chk("vec_valid_drop", {32'd0, out_valid}, 33'd0);
    end
    exp2 = '{32'd900, 32'd90, 32'd51, 32'd70};
    send(400, 500, 0, 0); send(40, 50, 0, 0); send(21, 30, 0, 0); send(20, 50, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_valid", {32'd0, out_valid}, 33'd1);
      chk("b2b_sum", {1'b0, sum}, {1'b0, exp2[i]});
      step();
    end
    chk("b2b_end", {32'd0, out_valid}, 33'd0);
    c0 = out_cnt;
    send(1, 2, 0, 0); send(3, 4, 0, 0); send(5, 6, 0, 0); send(7, 8, 0, 0);
    out_ready = 1'b0;
    #1;
    chk("stall_in_ready", {32'd0, in_ready}, 33'd0);
    held = sum;
    chk("stall_first", {1'b0, held}, 33'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_sum", {1'b0, sum}, {1'b0, held});
      chk("stall_valid", {32'd0, out_valid}, 33'd1);
      chk("stall_in_ready", {32'd0, in_ready}, 33'd0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("stall_delivered", 33'(out_cnt - c0), 33'd4);
    send(11, 1, 0, 0); send(12, 1, 0, 0); send(13, 1, 0, 0);
    a = 32'd99; b = 32'd1; in_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_valid", {32'd0, out_valid}, 33'd0);
    chk("flush_sum", {1'b0, sum}, 33'd0);
    chk("flush_cout", {32'd0, cout}, 33'd0);
    chk("flush_in_ready", {32'd0, in_ready}, 33'd1);
    c0 = out_cnt;
    for (int i = 0; i < 10; i++) step();
    chk("flush_none", 33'(out_cnt - c0), 33'd0);
`ifdef CLA_PIPE_OVF_EN
    send(32'h7FFF_FFFF, 32'd1, 0, 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("ovf_sum", {1'b0, sum}, 33'h0_8000_0000);
    chk("ovf_flag", {32'd0, ovf}, 33'd1);
    chk("ovf_cout", {32'd0, cout}, 33'd0);
    step();
`endif
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      a = ($urandom % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
      b = ($urandom % 8 == 0) ? 32'h0000_0001 : $urandom;
      cin = $urandom % 2;
      sub = $urandom % 2;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) step();
    chk("drain_empty", 33'(q.size()), 33'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
